// File: rtl/wb_pattern_pkg.sv
// wb_pattern_pkg: shared types, constants and the LFSR step function
// for the Wishbone pattern master.
package wb_pattern_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_INIT = 2'd1,
    ST_XFER      = 2'd2,
    ST_RESP      = 2'd3
  } state_t;

  localparam logic [2:0]  CTI_INCR          = 3'b010;
  localparam logic [2:0]  CTI_EOB           = 3'b111;

  // Galois taps x^32 + x^22 + x^2 + x + 1
  localparam logic [31:0] LFSR_MASK         = 32'h8020_0003;
  // An all-zero seed would lock the LFSR, so it is replaced by this value
  localparam logic [31:0] LFSR_DEFAULT_SEED = 32'h0000_0001;

  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    return {1'b0, s[31:1]} ^ (s[0] ? LFSR_MASK : 32'h0);
  endfunction

endpackage

// File: rtl/wb_pattern_master_lfsr.sv
// wb_pattern_lfsr: 32-bit Galois LFSR, reloaded with a seed per command
// and stepped once per acknowledged beat.
module wb_pattern_lfsr
  import wb_pattern_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [31:0] seed,
  input  logic        advance,
  output logic [31:0] lfsr_state
);

  // Load has priority; the two never coincide in the master's FSM
  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_state <= 32'h0;
    end else if (load) begin
      lfsr_state <= (seed == 32'h0) ? LFSR_DEFAULT_SEED : seed;
    end else if (advance) begin
      lfsr_state <= lfsr_next(lfsr_state);
    end
  end

endmodule

// File: rtl/wb_pattern_master.sv
// wb_pattern_master: self-checking Wishbone B3 burst master. Writes an LFSR
// pattern, or reads back and compares against the regenerated pattern.
// Optional feature macro: WB_TIMEOUT_EN enables the per-beat ack watchdog.
//
// state        | meaning
// -------------+-----------------------------------------------------
// ST_IDLE      | cmd_ready high, waiting for a command
// ST_WAIT_INIT | command latched, holding off until sdr_init_done
// ST_XFER      | cyc/stb high, one beat per ack
// ST_RESP      | one-cycle rsp_valid pulse, stats are final
module wb_pattern_master
  import wb_pattern_pkg::*;
#(
  parameter int AW          = 26,
  parameter int DW          = 32,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_i,
  input  logic            sdr_init_done,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic            cmd_we,
  input  logic [AW-1:0]   cmd_addr,
  input  logic [7:0]      cmd_len,
  input  logic [31:0]     cmd_seed,
  output logic            wb_cyc_o,
  output logic            wb_stb_o,
  output logic            wb_we_o,
  output logic [AW-1:0]   wb_addr_o,
  output logic [DW-1:0]   wb_dat_o,
  output logic [DW/8-1:0] wb_sel_o,
  output logic [2:0]      wb_cti_o,
  input  logic [DW-1:0]   wb_dat_i,
  input  logic            wb_ack_i,
  output logic            rsp_valid,
  output logic [15:0]     rsp_err_cnt,
  output logic [AW-1:0]   rsp_first_err_addr,
  output logic            rsp_timeout,
  output logic            busy
);

  localparam int            BYTES_PER_BEAT = DW / 8;
  localparam logic [AW-1:0] ADDR_STEP      = AW'(BYTES_PER_BEAT);
  localparam logic [AW-1:0] ALIGN_MASK     = ~(AW'(BYTES_PER_BEAT - 1));

  state_t      state;
  logic        we_q;
  logic [7:0]  beats_left;
  logic [31:0] lfsr_q;
  logic [31:0] lfsr_nxt;
  logic        accept;
  logic        beat_ack;
  logic        mismatch;
  logic        wdog_expire;

  // Replicate the 32-bit pattern across wide buses, truncate on narrow ones
  function automatic logic [DW-1:0] widen(input logic [31:0] w);
    logic [DW-1:0] r;
    for (int i = 0; i < DW; i++) begin
      r[i] = w[i % 32];
    end
    return r;
  endfunction

  assign wb_sel_o = '1;
  assign accept   = (state == ST_IDLE) && cmd_ready && cmd_valid;
  assign beat_ack = (state == ST_XFER) && wb_ack_i;
  assign lfsr_nxt = lfsr_next(lfsr_q);
  assign mismatch = !we_q && (wb_dat_i != widen(lfsr_q));

  wb_pattern_lfsr u_lfsr (
    .clk        (wb_clk_i),
    .rst        (wb_rst_i),
    .load       (accept),
    .seed       (cmd_seed),
    .advance    (beat_ack),
    .lfsr_state (lfsr_q)
  );

`ifdef WB_TIMEOUT_EN
  localparam logic [15:0] WDOG_LOAD = 16'(TIMEOUT_CYC - 1);

  logic [15:0] wdog;

  // Down-counter reloaded outside XFER and on every ack; zero means the
  // current beat has waited TIMEOUT_CYC cycles
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      wdog <= 16'h0;
    end else if ((state != ST_XFER) || wb_ack_i) begin
      wdog <= WDOG_LOAD;
    end else if (wdog != 16'h0) begin
      wdog <= wdog - 16'h1;
    end
  end

  assign wdog_expire = (state == ST_XFER) && !wb_ack_i && (wdog == 16'h0);
`else
  logic unused_timeout_cfg;

  assign unused_timeout_cfg = (TIMEOUT_CYC != 0);
  assign wdog_expire        = 1'b0;
`endif

  // Command sequencing, Wishbone beat generation and read-data checking
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state              <= ST_IDLE;
      we_q               <= 1'b0;
      beats_left         <= 8'h0;
      cmd_ready          <= 1'b0;
      busy               <= 1'b0;
      wb_cyc_o           <= 1'b0;
      wb_stb_o           <= 1'b0;
      wb_we_o            <= 1'b0;
      wb_addr_o          <= '0;
      wb_dat_o           <= '0;
      wb_cti_o           <= 3'b000;
      rsp_valid          <= 1'b0;
      rsp_err_cnt        <= 16'h0;
      rsp_first_err_addr <= '0;
      rsp_timeout        <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          busy      <= 1'b0;
          cmd_ready <= 1'b1;
          if (accept) begin
            cmd_ready          <= 1'b0;
            busy               <= 1'b1;
            we_q               <= cmd_we;
            wb_addr_o          <= cmd_addr & ALIGN_MASK;
            beats_left         <= cmd_len;
            rsp_err_cnt        <= 16'h0;
            rsp_first_err_addr <= '0;
            rsp_timeout        <= 1'b0;
            state              <= ST_WAIT_INIT;
          end
        end

        ST_WAIT_INIT: begin
          if (sdr_init_done) begin
            wb_cyc_o <= 1'b1;
            wb_stb_o <= 1'b1;
            wb_we_o  <= we_q;
            wb_dat_o <= we_q ? widen(lfsr_q) : '0;
            wb_cti_o <= (beats_left == 8'h0) ? CTI_EOB : CTI_INCR;
            state    <= ST_XFER;
          end
        end

        ST_XFER: begin
          if (wb_ack_i) begin
            if (mismatch) begin
              if (rsp_err_cnt != 16'hFFFF) begin
                rsp_err_cnt <= rsp_err_cnt + 16'h1;
              end
              // The counter saturates and never wraps, so zero means first
              if (rsp_err_cnt == 16'h0) begin
                rsp_first_err_addr <= wb_addr_o;
              end
            end
            wb_addr_o <= wb_addr_o + ADDR_STEP;
            if (beats_left == 8'h0) begin
              wb_cyc_o  <= 1'b0;
              wb_stb_o  <= 1'b0;
              wb_we_o   <= 1'b0;
              wb_dat_o  <= '0;
              wb_cti_o  <= 3'b000;
              rsp_valid <= 1'b1;
              state     <= ST_RESP;
            end else begin
              beats_left <= beats_left - 8'h1;
              wb_dat_o   <= we_q ? widen(lfsr_nxt) : '0;
              wb_cti_o   <= (beats_left == 8'h1) ? CTI_EOB : CTI_INCR;
            end
          end else if (wdog_expire) begin
            wb_cyc_o    <= 1'b0;
            wb_stb_o    <= 1'b0;
            wb_we_o     <= 1'b0;
            wb_dat_o    <= '0;
            wb_cti_o    <= 3'b000;
            rsp_timeout <= 1'b1;
            rsp_valid   <= 1'b1;
            state       <= ST_RESP;
          end
        end

        ST_RESP: begin
          busy      <= 1'b0;
          cmd_ready <= 1'b1;
          state     <= ST_IDLE;
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_pattern_master.sv
// tb_wb_pattern_master: directed bench for wb_pattern_master with a
// zero-wait-state Wishbone memory model on the bus.
module tb_wb_pattern_master;

  localparam int AW = 26;
  localparam int DW = 32;
`ifdef WB_TIMEOUT_EN
  localparam int TO_CYC = 16;
`else
  localparam int TO_CYC = 1024;
`endif

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [2:0]    cti;
    logic [DW-1:0] dat;
    logic          we;
  } beat_t;

  logic          clk;
  logic          wb_rst_i;
  logic          sdr_init_done;
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_we;
  logic [AW-1:0] cmd_addr;
  logic [7:0]    cmd_len;
  logic [31:0]   cmd_seed;
  logic          wb_cyc_o;
  logic          wb_stb_o;
  logic          wb_we_o;
  logic [AW-1:0] wb_addr_o;
  logic [DW-1:0] wb_dat_o;
  logic [3:0]    wb_sel_o;
  logic [2:0]    wb_cti_o;
  logic [DW-1:0] wb_dat_i;
  logic          wb_ack_i;
  logic          rsp_valid;
  logic [15:0]   rsp_err_cnt;
  logic [AW-1:0] rsp_first_err_addr;
  logic          rsp_timeout;
  logic          busy;

  logic          ack_en;
  logic [31:0]   mem [0:255];
  beat_t         beats[$];

  int n_checks = 0;
  int n_fail   = 0;

  wb_pattern_master #(.AW(AW), .DW(DW), .TIMEOUT_CYC(TO_CYC)) dut (
    .wb_clk_i           (clk),
    .wb_rst_i           (wb_rst_i),
    .sdr_init_done      (sdr_init_done),
    .cmd_valid          (cmd_valid),
    .cmd_ready          (cmd_ready),
    .cmd_we             (cmd_we),
    .cmd_addr           (cmd_addr),
    .cmd_len            (cmd_len),
    .cmd_seed           (cmd_seed),
    .wb_cyc_o           (wb_cyc_o),
    .wb_stb_o           (wb_stb_o),
    .wb_we_o            (wb_we_o),
    .wb_addr_o          (wb_addr_o),
    .wb_dat_o           (wb_dat_o),
    .wb_sel_o           (wb_sel_o),
    .wb_cti_o           (wb_cti_o),
    .wb_dat_i           (wb_dat_i),
    .wb_ack_i           (wb_ack_i),
    .rsp_valid          (rsp_valid),
    .rsp_err_cnt        (rsp_err_cnt),
    .rsp_first_err_addr (rsp_first_err_addr),
    .rsp_timeout        (rsp_timeout),
    .busy               (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Zero-wait-state slave: ack in the same cycle as stb
  assign wb_ack_i = wb_cyc_o & wb_stb_o & ack_en;
  assign wb_dat_i = mem[wb_addr_o[9:2]];

  // Log every acknowledged beat and perform writes
  always @(posedge clk) begin
    if (!wb_rst_i && wb_cyc_o && wb_stb_o && wb_ack_i) begin
      beats.push_back('{addr: wb_addr_o, cti: wb_cti_o, dat: wb_dat_o, we: wb_we_o});
      if (wb_we_o) mem[wb_addr_o[9:2]] <= wb_dat_o;
    end
  end

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return (s >> 1) ^ (s[0] ? 32'h8020_0003 : 32'h0);
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a command and return #1 after the edge that accepted it
  task automatic issue(input logic we, input logic [AW-1:0] addr, input logic [7:0] len,
                       input logic [31:0] seed);
    int n;
    cmd_we    = we;
    cmd_addr  = addr;
    cmd_len   = len;
    cmd_seed  = seed;
    cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < 50) begin
      tick();
      n++;
    end
    check("cmd_ready_seen", cmd_ready, 1);
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int budget, output int cycles);
    cycles = 0;
    while (!rsp_valid && cycles < budget) begin
      tick();
      cycles++;
    end
    check("rsp_valid_seen", rsp_valid, 1);
  endtask

  task automatic check_burst(input string nm, input logic [AW-1:0] base, input int nbeats,
                             input logic [31:0] seed, input logic we);
    logic [31:0]   s;
    logic [AW-1:0] a;
    beat_t         b;
    s = (seed == 32'h0) ? 32'h1 : seed;
    check({nm, "_beats"}, beats.size(), nbeats);
    for (int i = 0; i < nbeats; i++) begin
      if (i < beats.size()) b = beats[i];
      else b = '0;
      a = base + AW'(4 * i);
      check($sformatf("%s_addr%0d", nm, i), b.addr, a);
      check($sformatf("%s_cti%0d", nm, i), b.cti, (i == nbeats - 1) ? 3'b111 : 3'b010);
      check($sformatf("%s_dat%0d", nm, i), b.dat, we ? s : 32'h0);
      check($sformatf("%s_we%0d", nm, i), b.we, we);
      s = lfsr_step(s);
    end
  endtask

  initial begin
    int cyc_cnt;
    logic seen;

    wb_rst_i      = 1'b1;
    sdr_init_done = 1'b1;
    cmd_valid     = 1'b0;
    cmd_we        = 1'b0;
    cmd_addr      = '0;
    cmd_len       = 8'h0;
    cmd_seed      = 32'h0;
    ack_en        = 1'b1;

    // Reset state
    repeat (3) tick();
    check("rst_cyc", wb_cyc_o, 0);
    check("rst_stb", wb_stb_o, 0);
    check("rst_cmd_ready", cmd_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_sel", wb_sel_o, 4'hF);
    check("rst_cti", wb_cti_o, 3'b000);
    check("rst_dat", wb_dat_o, 32'h0);
    check("rst_timeout", rsp_timeout, 0);
    wb_rst_i = 1'b0;
    tick();
    check("idle_ready", cmd_ready, 1);

    // Write burst: 8 beats, 1 beat per cycle, accept-to-cyc = 2 cycles
    beats.delete();
    issue(1'b1, 26'h0000100, 8'd7, 32'hCAFE_0001);
    wait_rsp(100, cyc_cnt);
    check("wr_latency", cyc_cnt, 9);
    check_burst("wr", 26'h0000100, 8, 32'hCAFE_0001, 1'b1);
    check("wr_beat1_hand", (beats.size() > 1) ? beats[1].dat : 32'h0, 32'hE55F_0003);
    check("wr_beat2_hand", (beats.size() > 2) ? beats[2].dat : 32'h0, 32'hF28F_8002);
    check("wr_err_cnt", rsp_err_cnt, 0);
    check("wr_timeout", rsp_timeout, 0);
    tick();
    check("wr_rsp_pulse", rsp_valid, 0);
    check("wr_busy_after", busy, 0);

    // Read back with the same seed
    beats.delete();
    issue(1'b0, 26'h0000100, 8'd7, 32'hCAFE_0001);
    wait_rsp(100, cyc_cnt);
    check("rd_latency", cyc_cnt, 9);
    check_burst("rd", 26'h0000100, 8, 32'hCAFE_0001, 1'b0);
    check("rd_err_cnt", rsp_err_cnt, 0);
    check("rd_first_err", rsp_first_err_addr, 0);

    // Read back with a different seed: every beat mismatches
    beats.delete();
    issue(1'b0, 26'h0000100, 8'd7, 32'h0000_1234);
    wait_rsp(100, cyc_cnt);
    check("bad_err_cnt", rsp_err_cnt, 8);
    check("bad_first_err", rsp_first_err_addr, 26'h0000100);
    tick();
    check("bad_hold_cnt", rsp_err_cnt, 8);

    // Init gating
    sdr_init_done = 1'b0;
    beats.delete();
    issue(1'b1, 26'h0000200, 8'd0, 32'h0000_0005);
    seen = 1'b0;
    repeat (50) begin
      tick();
      seen = seen | wb_cyc_o;
    end
    check("gate_no_cyc", seen, 0);
    check("gate_busy", busy, 1);
    sdr_init_done = 1'b1;
    tick();
    check("gate_cyc_rise", wb_cyc_o, 1);
    wait_rsp(10, cyc_cnt);

    // Single beat with seed 0
    beats.delete();
    issue(1'b1, 26'h0000104, 8'd0, 32'h0);
    check("one_cyc_accept", wb_cyc_o, 0);
    tick();
    check("one_cyc", wb_cyc_o, 1);
    check("one_cti", wb_cti_o, 3'b111);
    check("one_dat", wb_dat_o, 32'h0000_0001);
    check("one_addr", wb_addr_o, 26'h0000104);
    tick();
    check("one_rsp_valid", rsp_valid, 1);
    check("one_cyc_drop", wb_cyc_o, 0);
    tick();
    check("one_rsp_pulse", rsp_valid, 0);
    check("one_beats", beats.size(), 1);

    // Address wrap, unaligned low bits ignored
    beats.delete();
    issue(1'b1, 26'h3FFFFFE, 8'd1, 32'h0000_0007);
    wait_rsp(20, cyc_cnt);
    check_burst("wrap", 26'h3FFFFFC, 2, 32'h0000_0007, 1'b1);
    check("wrap_beat1_hand", (beats.size() > 1) ? beats[1].dat : 32'h0, 32'h8020_0000);

    // Reset on beat 3 of a 16-beat burst
    beats.delete();
    issue(1'b1, 26'h0000000, 8'd15, 32'h0000_0009);
    cyc_cnt = 0;
    while (beats.size() < 2 && cyc_cnt < 20) begin
      tick();
      cyc_cnt++;
    end
    check("mid_beats_before_rst", beats.size(), 2);
    check("mid_cyc_before_rst", wb_cyc_o, 1);
    wb_rst_i = 1'b1;
    tick();
    check("mid_cyc", wb_cyc_o, 0);
    check("mid_stb", wb_stb_o, 0);
    check("mid_busy", busy, 0);
    wb_rst_i = 1'b0;
    seen = 1'b0;
    repeat (20) begin
      tick();
      seen = seen | rsp_valid | wb_cyc_o;
    end
    check("mid_no_rsp", seen, 0);
    check("mid_ready", cmd_ready, 1);

`ifdef WB_TIMEOUT_EN
    // Ack withheld: watchdog ends the command after TO_CYC cycles in XFER
    ack_en = 1'b0;
    issue(1'b0, 26'h0000100, 8'd3, 32'h0000_0001);
    tick();
    cyc_cnt = 0;
    while (wb_cyc_o && cyc_cnt < 100) begin
      cyc_cnt++;
      tick();
    end
    check("to_xfer_cycles", cyc_cnt, 16);
    check("to_rsp_valid", rsp_valid, 1);
    check("to_rsp_timeout", rsp_timeout, 1);
    ack_en = 1'b1;
`else
    // Ack withheld: without the watchdog the beat waits indefinitely
    ack_en = 1'b0;
    beats.delete();
    issue(1'b0, 26'h0000100, 8'd0, 32'hCAFE_0001);
    repeat (60) tick();
    check("hold_cyc", wb_cyc_o, 1);
    check("hold_no_rsp", rsp_valid, 0);
    ack_en = 1'b1;
    wait_rsp(5, cyc_cnt);
    check("hold_timeout", rsp_timeout, 0);
    check("hold_err_cnt", rsp_err_cnt, 0);
`endif

    repeat (2) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: observed simulation still running, expected finish");
    $fatal(1, "global timeout");
  end

endmodule

// File: doc/wb_pattern_master.md
Name: wb_pattern_master

Overview:
- Self-checking Wishbone B3 master that drives the SDRAM controller's Wishbone slave port (wb_stb_i/wb_cyc_i/... of sdrc_top) in the p2 environment.
- Accepts write-burst and read-burst commands on a valid/ready port.
- Generates LFSR data for writes and regenerates the same sequence to check read data.
- Reports a per-command error count and the first failing address.

Parameters:
- AW, 26, Wishbone byte-address width
- DW, 32, Wishbone data width (multiple of 8)
- TIMEOUT_CYC, 1024, ack watchdog limit in cycles (used only with WB_TIMEOUT_EN)

Ports:
- wb_clk_i  in  1  system clock, all logic on rising edge
- wb_rst_i  in  1  synchronous active-high reset
- sdr_init_done  in  1  controller init complete; no bus cycle starts while low
- cmd_valid  in  1  command request
- cmd_ready  out  1  command accepted when valid&ready
- cmd_we  in  1  1 = write burst, 0 = read-and-check burst
- cmd_addr  in  AW  start byte address, DW/8-aligned (low bits ignored)
- cmd_len  in  8  beats minus one (0 -> 1 beat, 255 -> 256 beats)
- cmd_seed  in  32  LFSR seed; 0 is replaced by 32'h1
- wb_cyc_o, wb_stb_o, wb_we_o  out  1 each  Wishbone master controls
- wb_addr_o  out  AW  beat address
- wb_dat_o  out  DW  write data
- wb_sel_o  out  DW/8  byte enables, all ones
- wb_cti_o  out  3  cycle type
- wb_dat_i  in  DW  read data
- wb_ack_i  in  1  slave acknowledge
- rsp_valid  out  1  one-cycle pulse at command completion
- rsp_err_cnt  out  16  mismatching read beats, saturating at 16'hFFFF
- rsp_first_err_addr  out  AW  address of first mismatch (0 if none)
- rsp_timeout  out  1  command aborted by watchdog
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset: all outputs 0 at the edge where wb_rst_i is sampled high, except wb_sel_o, which is always all ones. FSM goes to IDLE and the LFSR is cleared. Reset mid-burst drops cyc/stb next edge; no response is issued.
- FSM states: IDLE, WAIT_INIT, XFER, RESP.
- IDLE:
  - cmd_ready=1.
  - On accept, latch cmd_we, aligned addr, beat counter=cmd_len, LFSR=seed (or 1).
  - Clear error stats; go to WAIT_INIT.
- WAIT_INIT:
  - cmd_ready=0.
  - Go to XFER on the first cycle sdr_init_done=1.
  - If already 1 on entry, XFER follows next cycle (accept-to-cyc latency = 2 cycles).
- XFER:
  - cyc=stb=1, wb_we_o=latched we, wb_dat_o=LFSR state (writes; 0 for reads).
  - Outputs are held stable until wb_ack_i.
  - wb_cti_o = 3'b010 while beats remain, 3'b111 on the last beat (1-beat command: 3'b111 only).
- Ack cycle handling (same cycle as wb_ack_i):
  - Reads: compare wb_dat_i against the LFSR. On mismatch, increment err_cnt (saturating); record the address if it is the first mismatch.
  - Advance the LFSR, addr += DW/8 (wraps modulo 2^AW), decrement the beat counter.
  - Registered outputs present the next beat on the following cycle, so cyc/stb stay high across beats (1 beat/cycle peak).
  - On the last-beat ack, drop cyc/stb next edge and go to RESP.
- RESP: rsp_valid=1 for one cycle, then IDLE. rsp_* hold their values until the next accepted command.
- LFSR: 32-bit Galois, taps x^32+x^22+x^2+x+1 (mask 32'h8020_0003). Shift right; if the output bit is 1, XOR the mask. DW>32 repeats the word; DW<32 uses the low bits.
- wb_ack_i outside XFER is ignored. cmd_valid outside IDLE is not accepted.

Optional Feature:
- Macro: WB_TIMEOUT_EN.
- With it defined:
  - 16-bit watchdog clears on each ack and on XFER entry, counts cycles in XFER.
  - At TIMEOUT_CYC without ack: drop cyc/stb, set rsp_timeout=1, go to RESP. Remaining beats are skipped.
- Without it: no counter exists, XFER waits indefinitely, rsp_timeout is tied to 0.

Decomposition:
- Package wb_pattern_pkg holds:
  - state enum
  - CTI constants CTI_INCR=3'b010, CTI_EOB=3'b111
  - LFSR_MASK, the default seed, and the next-LFSR function
- One natural sub-module: wb_pattern_lfsr (load, advance, state out), instantiated once and reloaded per command.

Test Plan:
- Write then read, same seed: write addr 26'h0000100, len 7, seed 32'hCAFE_0001; read with the same args -> 8 acks each, cti 010×7 then 111, addresses 0x100..0x11C, rsp_err_cnt=0, rsp_first_err_addr=0.
- Read with a different seed: seed 32'h1234 over the data above -> rsp_err_cnt=8, rsp_first_err_addr=26'h0000100.
- Init gating: hold sdr_init_done=0 for 50 cycles after accept -> cyc stays 0; cyc rises 1 cycle after init_done rises.
- Single beat, seed 0: len 0 -> one beat, cti=111, wb_dat_o=32'h0000_0001, rsp_valid 1 cycle after ack.
- Address wrap: addr 26'h3FFFFFC, len 1 -> second beat address 26'h0000000.
- Reset and timeout:
  - Assert wb_rst_i on beat 3 of a 16-beat burst -> cyc/stb/busy are 0 next edge, no rsp_valid.
  - With WB_TIMEOUT_EN, TIMEOUT_CYC=16 and ack withheld -> rsp_timeout=1, rsp_valid at cycle 17 of XFER.
